// File: rtl/detect_event_counter_pkg.sv
// detect_event_counter_pkg: window FSM state encoding and window-count width helper.
package detect_event_counter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;
  function automatic int win_w(input int window);
    return $clog2(window + 1);
  endfunction
endpackage

// File: rtl/detect_event_counter_if.sv
// detect_event_counter_if: hit/enable/clear inputs and count/alarm results of the event counter.
interface detect_event_counter_if
  import detect_event_counter_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 16
);
  localparam int WIN_W = win_w(WINDOW);
  logic             hit;
  logic             en;
  logic             clear;
  logic [CNT_W-1:0] total_count;
  logic [WIN_W-1:0] window_count;
  logic             window_valid;
  logic             alarm;
  logic             alarm_sticky;
  modport master (
    output hit, en, clear,
    input  total_count, window_count, window_valid, alarm, alarm_sticky
  );
  modport slave (
    input  hit, en, clear,
    output total_count, window_count, window_valid, alarm, alarm_sticky
  );
endinterface

// File: rtl/detect_event_counter_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
  end
endmodule

// File: rtl/detect_event_counter.sv
// detect_event_counter: counts detector hits into a saturating total and fixed windows with alarm.
// Define HIT_EDGE_EN to count only rising edges of hit instead of every high cycle.
module detect_event_counter
  import detect_event_counter_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int THRESH = 3,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  reset,
  detect_event_counter_if.slave bus
);
  localparam int WIN_W = win_w(WINDOW);
  localparam int CYC_W = $clog2(WINDOW);
  state_t           state;
  logic [CYC_W-1:0] cyc;
  logic [WIN_W-1:0] acc;
  logic [WIN_W-1:0] sum;
  logic             h;
  logic             close;
`ifdef HIT_EDGE_EN
  logic hit_q;
  always_ff @(posedge clk) hit_q <= reset ? 1'b0 : bus.hit;
  assign h = bus.hit & ~hit_q;
`else
  assign h = bus.hit;
`endif
  assign sum   = acc + WIN_W'(h);
  assign close = state == COUNT && bus.en && cyc == CYC_W'(WINDOW - 1);
  sat_counter #(.W(CNT_W)) u_total (
    .clk  (clk),
    .reset(reset),
    .inc  (h),
    .clr  (bus.clear),
    .count(bus.total_count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cyc              <= '0;
      acc              <= '0;
      bus.window_count <= '0;
      bus.window_valid <= 1'b0;
      bus.alarm        <= 1'b0;
    end else begin
      bus.window_valid <= 1'b0;
      case (state)
        IDLE: if (bus.en) begin
          state <= COUNT;
          cyc   <= '0;
          acc   <= '0;
        end
        COUNT: if (!bus.en) state <= IDLE;
        else if (close) begin
          state            <= REPORT;
          bus.window_valid <= 1'b1;
          bus.window_count <= sum;
          bus.alarm        <= sum >= WIN_W'(THRESH);
        end else begin
          acc <= sum;
          cyc <= cyc + CYC_W'(1);
        end
        REPORT: begin
          cyc   <= '0;
          acc   <= WIN_W'(h);
          state <= bus.en ? COUNT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // clear beats an alarm being loaded in the same cycle
  always_ff @(posedge clk) begin
    if (reset || bus.clear) bus.alarm_sticky <= 1'b0;
    else if (close && sum >= WIN_W'(THRESH)) bus.alarm_sticky <= 1'b1;
  end
endmodule
